// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared widths, request type and enums for the main-memory
//             arbiter (icache / dcache miss ports -> main memory).
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int PC_WIDTH          = 32;
    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int DCACHE_LINE_WIDTH = ICACHE_LINE_WIDTH;

    typedef logic [ICACHE_LINE_WIDTH-1:0] line_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          addr;
        logic                         is_store;
        logic [DCACHE_LINE_WIDTH-1:0] data;
    } memory_request_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundle of the cache-side and memory-side handshake signals of
//             the memory arbiter. slave = arbiter view, master = environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                                ic_req_valid;
    memory_request_t                     ic_req_info;
    logic                                ic_rsp_valid;
    logic [ICACHE_LINE_WIDTH-1:0]        ic_rsp_data;

    logic                                dc_req_valid;
    memory_request_t                     dc_req_info;
    logic                                dc_rsp_valid;
    logic [DCACHE_LINE_WIDTH-1:0]        dc_rsp_data;

    logic                                mem_req_valid;
    memory_request_t                     mem_req_info;
    logic                                mem_rsp_valid;
    logic [ICACHE_LINE_WIDTH-1:0]        mem_rsp_data;

    modport slave (
        input  ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
               mem_rsp_valid, mem_rsp_data,
        output ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
               mem_req_valid, mem_req_info
    );

    modport master (
        output ic_req_valid, ic_req_info, dc_req_valid, dc_req_info,
               mem_rsp_valid, mem_rsp_data,
        input  ic_rsp_valid, ic_rsp_data, dc_rsp_valid, dc_rsp_data,
               mem_req_valid, mem_req_info
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_slot.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_slot
//  Purpose  : One pending-miss slot (valid + request). A new request in the
//             same cycle the slot is being issued wins over the clear.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_slot
    import mem_arbiter_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            set_i,
    input  memory_request_t info_i,
    input  logic            clear_i,
    output logic            valid_o,
    output memory_request_t info_o
);

    logic            valid_q, valid_d;
    memory_request_t info_q,  info_d;
    logic            accept;

    // A pulse into an occupied slot is dropped unless the slot empties now.
    assign accept = set_i && (!valid_q || clear_i);

    // Next-state: clear first, then let an accepted request override it.
    always_comb begin
        valid_d = valid_q;
        info_d  = info_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d = 1'b1;
            info_d  = info_i;
        end
    end

    // Slot register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            info_q  <= '0;
        end else begin
            valid_q <= valid_d;
            info_q  <= info_d;
        end
    end

    assign valid_o = valid_q;
    assign info_o  = info_q;

    // Requesters promise one outstanding miss; flag any overrun.
    a_no_overrun: assert property (@(posedge clock) disable iff (reset)
        !(set_i && valid_q && !clear_i))
        else $error("mem_arb_slot: request dropped, slot already occupied");

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Serialises icache and dcache misses onto a single main-memory
//             port, one transaction in flight, response routed to owner.
//  Options  : MEM_ARB_ROUND_ROBIN_EN - two-entry round-robin on collision;
//             undefined gives fixed priority with the dcache winning.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t      state_q, state_d;
    arb_owner_t      owner_q, owner_d;
    line_t           rsp_data_q, rsp_data_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_t      rr_ptr_q, rr_ptr_d;
`endif

    logic            ic_valid, dc_valid;
    memory_request_t ic_info, dc_info;
    logic            issue;
    arb_owner_t      winner;

    assign issue = (state_q == ST_ISSUE);

    mem_arb_slot u_ic_slot (
        .clock   (clock),
        .reset   (reset),
        .set_i   (bus.ic_req_valid),
        .info_i  (bus.ic_req_info),
        .clear_i (issue && (owner_q == OWNER_IC)),
        .valid_o (ic_valid),
        .info_o  (ic_info)
    );

    mem_arb_slot u_dc_slot (
        .clock   (clock),
        .reset   (reset),
        .set_i   (bus.dc_req_valid),
        .info_i  (bus.dc_req_info),
        .clear_i (issue && (owner_q == OWNER_DC)),
        .valid_o (dc_valid),
        .info_o  (dc_info)
    );

    // Winner selection among valid slots; only meaningful in IDLE.
    always_comb begin
        winner = OWNER_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ic_valid && dc_valid) begin
            winner = rr_ptr_q;
        end else if (dc_valid) begin
            winner = OWNER_DC;
        end
`else
        if (dc_valid) begin
            winner = OWNER_DC;
        end
`endif
    end

    // FSM next-state, owner latch, response capture and pointer update.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ic_valid || dc_valid) begin
                    owner_d = winner;
                    state_d = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = (winner == OWNER_IC) ? OWNER_DC : OWNER_IC;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    rsp_data_d = bus.mem_rsp_data;
                    state_d    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_IC;
            rsp_data_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= OWNER_IC;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Outputs decode from registered state, so reset clears them at once.
    assign bus.mem_req_valid = issue;
    assign bus.mem_req_info  = !issue ? '0 :
                               ((owner_q == OWNER_DC) ? dc_info : ic_info);
    assign bus.ic_rsp_valid  = (state_q == ST_RESPOND) && (owner_q == OWNER_IC);
    assign bus.dc_rsp_valid  = (state_q == ST_RESPOND) && (owner_q == OWNER_DC);
    assign bus.ic_rsp_data   = rsp_data_q;
    assign bus.dc_rsp_data   = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus
//             random traffic against a transaction-level timing model.
//  Options  : MEM_ARB_ROUND_ROBIN_EN selects the round-robin expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clock;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nassert = 0;
    int nfail   = 0;

    // Reference model: pending request per cache, one memory transaction.
    int              cyc;
    bit              pv[2];
    memory_request_t pinfo[2];
    int              pt[2];
    bit              busy;
    int              own;
    int              issue_cyc;
    int              rsp_sched;
    int              next_free;
    int              pref;
    int              rsp_cyc;
    int              rsp_own;
    line_t           held;
    bit              last_icr, last_dcr;

    // Stimulus controls.
    bit              s_ic, s_dc, s_stray, rnd_en, use_fixed;
    memory_request_t s_ici, s_dci;
    int              lat;
    line_t           fixed_line;

    function automatic line_t rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic memory_request_t mk_req(input logic [31:0] a, input bit st,
                                               input line_t d);
        memory_request_t r;
        r.addr = a; r.is_store = st; r.data = d;
        return r;
    endfunction

    function automatic memory_request_t rand_req(input bit is_dc);
        memory_request_t r;
        r = '0;
        r.addr = $urandom();
        if (is_dc && ($urandom_range(0, 1) == 1)) begin
            r.is_store = 1'b1;
            r.data     = rand_line();
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        nassert++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        pv[0] = 0; pv[1] = 0; busy = 0; own = 0; issue_cyc = -10; rsp_sched = -1;
        next_free = 0; pref = 0; rsp_cyc = -1; rsp_own = 0; held = '0;
        last_icr = 0; last_dcr = 0;
    endtask

    task automatic drive_idle();
        bus.ic_req_valid = 0; bus.ic_req_info = '0;
        bus.dc_req_valid = 0; bus.dc_req_info = '0;
        bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    endtask

    task automatic chk_all_zero(input string where);
        chk({where, ".mem_req_valid"}, 192'(bus.mem_req_valid), 192'(0));
        chk({where, ".mem_req_info"},  192'(bus.mem_req_info),  192'(0));
        chk({where, ".ic_rsp_valid"},  192'(bus.ic_rsp_valid),  192'(0));
        chk({where, ".dc_rsp_valid"},  192'(bus.dc_rsp_valid),  192'(0));
        chk({where, ".ic_rsp_data"},   192'(bus.ic_rsp_data),   192'(0));
        chk({where, ".dc_rsp_data"},   192'(bus.dc_rsp_data),   192'(0));
    endtask

    // One clock cycle: predict, drive, sample at negedge, then advance model.
    task automatic step();
        bit              exp_issue, ci, cd, mrv, eicr, edcr;
        int              w;
        memory_request_t exp_info;
        line_t           mrd;
        @(posedge clock); #1; cyc++;
        // A grant needs the slot set two cycles earlier and a free arbiter.
        exp_issue = 0; w = 0;
        ci = pv[0] && (pt[0] <= cyc - 2);
        cd = pv[1] && (pt[1] <= cyc - 2);
        if (!busy && (cyc >= next_free) && (ci || cd)) begin
            exp_issue = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = (ci && cd) ? pref : (cd ? 1 : 0);
`else
            w = cd ? 1 : 0;
`endif
        end
        exp_info = exp_issue ? pinfo[w] : '0;
        eicr = (rsp_cyc == cyc) && (rsp_own == 0);
        edcr = (rsp_cyc == cyc) && (rsp_own == 1);
        if (rnd_en) begin
            if (!pv[0] || (exp_issue && w == 0)) begin
                s_ic = ($urandom_range(0, 3) == 0); s_ici = rand_req(0);
            end
            if (!pv[1] || (exp_issue && w == 1)) begin
                s_dc = ($urandom_range(0, 3) == 0); s_dci = rand_req(1);
            end
            s_stray = !busy && ($urandom_range(0, 7) == 0);
        end
        bus.ic_req_valid = s_ic; bus.ic_req_info = s_ic ? s_ici : '0;
        bus.dc_req_valid = s_dc; bus.dc_req_info = s_dc ? s_dci : '0;
        mrv = (busy && cyc == rsp_sched) || s_stray;
        mrd = use_fixed ? fixed_line : rand_line();
        bus.mem_rsp_valid = mrv; bus.mem_rsp_data = mrv ? mrd : '0;
        @(negedge clock);
        chk("mem_req_valid", 192'(bus.mem_req_valid), 192'(exp_issue));
        chk("mem_req_info",  192'(bus.mem_req_info),  192'(exp_info));
        chk("ic_rsp_valid",  192'(bus.ic_rsp_valid),  192'(eicr));
        chk("dc_rsp_valid",  192'(bus.dc_rsp_valid),  192'(edcr));
        chk("ic_rsp_data",   192'(bus.ic_rsp_data),   192'(held));
        chk("dc_rsp_data",   192'(bus.dc_rsp_data),   192'(held));
        last_icr = eicr; last_dcr = edcr;
        if (exp_issue) begin
            pv[w] = 0; busy = 1; own = w; issue_cyc = cyc; pref = 1 - w;
            rsp_sched = cyc + (rnd_en ? $urandom_range(1, 6) : lat);
        end
        if (busy && mrv && cyc > issue_cyc) begin
            busy = 0; held = mrd; rsp_cyc = cyc + 1; rsp_own = own; next_free = cyc + 3;
        end
        if (s_ic && !pv[0]) begin pv[0] = 1; pinfo[0] = s_ici; pt[0] = cyc; end
        if (s_dc && !pv[1]) begin pv[1] = 1; pinfo[1] = s_dci; pt[1] = cyc; end
        s_ic = 0; s_dc = 0; s_stray = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; cyc = 0; lat = 5; rnd_en = 0; use_fixed = 0;
        s_ic = 0; s_dc = 0; s_stray = 0; s_ici = '0; s_dci = '0; fixed_line = '0;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clock);
        #1 chk_all_zero("reset");
        @(negedge clock); reset = 1'b0;

        // Single icache miss, memory latency 5, line of 0xA5 bytes.
        use_fixed = 1; fixed_line = {16{8'hA5}}; lat = 5;
        s_ic = 1; s_ici = mk_req(32'h1000, 0, '0);
        run(12);
        use_fixed = 0;

        // Simultaneous IC 0x2000 / DC 0x3000.
        lat = 3;
        s_ic = 1; s_ici = mk_req(32'h2000, 0, '0);
        s_dc = 1; s_dci = mk_req(32'h3000, 0, '0);
        run(20);

        // Dcache store with data 0xDEAD.
        s_dc = 1; s_dci = mk_req(32'h4000, 1, line_t'(16'hDEAD));
        run(10);

        // New request in the same cycle its slot is issued is kept.
        s_ic = 1; s_ici = mk_req(32'h5000, 0, '0);
        step(); step();
        s_ic = 1; s_ici = mk_req(32'h5040, 0, '0);
        run(16);

        // Repeated contention: both re-request right after each response.
        lat = 2;
        s_ic = 1; s_ici = mk_req(32'h6000, 0, '0);
        s_dc = 1; s_dci = mk_req(32'h7000, 0, '0);
        for (int n = 0; n < 60; n++) begin
            if (last_icr) begin s_ic = 1; s_ici = mk_req(32'h6000 + 32'(n), 0, '0); end
            if (last_dcr) begin s_dc = 1; s_dci = mk_req(32'h7000 + 32'(n), 0, '0); end
            step();
        end
        run(12);

        // Stray memory response while idle.
        s_stray = 1;
        run(4);

        // Reset during WAIT, stale response afterwards, then a clean miss.
        lat = 30;
        s_ic = 1; s_ici = mk_req(32'h8000, 0, '0);
        run(5);
        @(posedge clock); cyc++; #3;
        drive_idle();
        reset = 1'b1;
        #1 chk_all_zero("reset_in_wait");
        @(posedge clock); cyc++;
        @(negedge clock); reset = 1'b0;
        model_clear();
        s_stray = 1;
        run(3);
        lat = 3;
        s_dc = 1; s_dci = mk_req(32'h9000, 0, '0);
        run(10);

        // Random traffic.
        rnd_en = 1;
        run(2000);
        rnd_en = 0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
`default_nettype wire
